cluster_unpacker: RTL and testbench
===================================

CLUSTER_UNPACKER -- requirements
Module: cluster_unpacker

Interface
REQ-001 Parameter MXVPF, default 1536: number of strip-cluster positions (vpf bitmap width).
REQ-002 Parameter MXCLST, default 8: clusters per frame.
REQ-003 clock4x  in  1  160 MHz clock; all state changes on its rising edge.
REQ-004 global_reset  in  1  reset, asynchronous, active-high.
REQ-005 valid_in  in  1  frame strobe; adr0..adr7/cnt0..cnt7 are valid while it is high.
REQ-006 adr0..adr7  in  11 each  cluster start addresses; any value >= MXVPF (e.g. 0x7FF) means "no cluster".
REQ-007 cnt0..cnt7  in  3 each  cluster size codes for the matching address.
REQ-008 busy  out  1  high while a frame is being unpacked.
REQ-009 done  out  1  one-cycle pulse when vpfs_out/cnts_out update.
REQ-010 overflow  out  1  one-cycle pulse when a valid_in strobe is dropped.
REQ-011 vpfs_out  out  MXVPF  reconstructed cluster-start bitmap.
REQ-012 cnts_out  out  MXVPF*3  reconstructed size codes; bits [3i+2:3i] belong to position i.
REQ-013 strips_out  out  MXVPF  expanded strip-hit map (see Configuration).

Function
REQ-014 FSM states: IDLE, SCAN; index counter idx (3 bits) selects the cluster processed in SCAN.
REQ-015 IDLE with valid_in=1 at edge T: latch all 8 adr/cnt pairs, clear accumulator bitmaps, idx=0, go SCAN.
REQ-016 SCAN at edges T+1..T+8: merge cluster idx into accumulator (vpf bit adr set, cnt field at adr written), idx increments.
REQ-017 Clusters with adr >= MXVPF are skipped; accumulator unchanged for that slot.
REQ-018 Duplicate addresses in one frame: later slot's cnt overwrites earlier; vpf bit remains set.
REQ-019 At edge T+8 (idx=7), vpfs_out/cnts_out/strips_out load accumulator including slot 7; done high for the following cycle.
REQ-020 Latency: valid_in at edge T -> done and new outputs visible after edge T+8.
REQ-021 valid_in during the final SCAN cycle (idx=7) is accepted as a new frame, sustaining an 8-cycle cadence with no gap.
REQ-022 valid_in in SCAN with idx<7 is ignored; overflow pulses one cycle; current frame unaffected.
REQ-023 Outputs hold between done pulses; busy = (state==SCAN).
REQ-024 An all-invalid frame still completes: done pulses, outputs become all zero.

Reset
REQ-025 global_reset asserted: state=IDLE, idx=0, busy=0, done=0, overflow=0, vpfs_out/cnts_out/strips_out/accumulators=0, immediately, independent of clock4x.
REQ-026 Reset mid-frame discards the frame; no done pulse follows; first valid_in after deassertion starts a fresh frame.

Configuration
REQ-027 Macro CLUSTER_UNPACKER_STRIPS_EN defined: strips_out sets bits adr..adr+cnt per valid cluster, clipped at MXVPF-1, accumulated like vpfs_out.
REQ-028 Macro not defined: strips_out tied to 0, no strip-expansion logic synthesised; all other behaviour identical.

Structure
REQ-029 Shared package cluster_pkg holds MXVPF, MXCLST, ADR_W=11, CNT_W=3, ADR_INVALID=11'h7FF and the cluster (adr,cnt) struct typedef.
REQ-030 One sub-module, cluster_slot_decoder: combinational adr/cnt -> one-hot vpf word and strip-range mask, instantiated once, muxed by idx.

Verification
REQ-031 Frame adr0..7 = 0,1,2,3,4,5,6,1535, all cnt=3 -> done at T+8; vpfs_out bits 0-6,1535 set; those cnt fields =3.
REQ-032 All adr=0x7FF -> done at T+8; vpfs_out=0, cnts_out=0.
REQ-033 Frames strobed at T and T+8 -> two done pulses at T+8 and T+16, overflow never asserted.
REQ-034 Strobe at T, second strobe at T+3 -> overflow pulses once, first frame output correct, no second done.
REQ-035 adr0=100 cnt=2, adr3=100 cnt=5 -> vpfs_out[100]=1, cnts_out field 100 = 5.
REQ-036 With CLUSTER_UNPACKER_STRIPS_EN, adr=1534 cnt=7 -> strips_out bits 1534,1535 set only; global_reset asserted at T+4 -> all outputs 0 immediately, no done.

Source files
------------

// File: rtl/cluster_pkg.sv
// cluster_pkg: shared widths, limits, cluster record and FSM state for the cluster unpacker
package cluster_pkg;
  localparam int MXVPF = 1536;
  localparam int MXCLST = 8;
  localparam int ADR_W = 11;
  localparam int CNT_W = 3;
  localparam logic [ADR_W-1:0] ADR_INVALID = 11'h7FF;
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [CNT_W-1:0] cnt;
  } cluster_t;
  typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/cluster_slot_decoder.sv
// cluster_slot_decoder: one cluster (adr,cnt) -> one-hot start bit and strip-range mask
// ports: adr/cnt cluster in; vpf one-hot start bit; strips bits adr..adr+cnt (zero unless CLUSTER_UNPACKER_STRIPS_EN)
module cluster_slot_decoder #(
  parameter int MXVPF = cluster_pkg::MXVPF
) (
  input  logic [cluster_pkg::ADR_W-1:0] adr,
  input  logic [cluster_pkg::CNT_W-1:0] cnt,
  output logic [MXVPF-1:0]              vpf,
  output logic [MXVPF-1:0]              strips
);
  // an address past the bitmap shifts the bit out, so invalid slots decode to zero
  assign vpf = MXVPF'(1) << adr;
`ifdef CLUSTER_UNPACKER_STRIPS_EN
  // the range ends naturally at MXVPF-1 because i never reaches MXVPF
  always_comb
    for (int i = 0; i < MXVPF; i++)
      strips[i] = i >= int'(adr) && i <= int'(adr) + int'(cnt);
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt;
  assign strips = '0;
`endif
endmodule

// File: rtl/cluster_unpacker.sv
// cluster_unpacker: rebuilds vpf/cnt bitmaps from an 8-cluster frame, one cluster per clock
// ports: clock4x, global_reset (async, active-high); valid_in + adr0..7/cnt0..7 frame in;
//        busy/done/overflow status; vpfs_out/cnts_out/strips_out bitmaps
// macro CLUSTER_UNPACKER_STRIPS_EN enables the strips_out expansion, otherwise strips_out is 0
module cluster_unpacker #(
  parameter int MXVPF  = cluster_pkg::MXVPF,
  parameter int MXCLST = cluster_pkg::MXCLST
) (
  input  logic                           clock4x,
  input  logic                           global_reset,
  input  logic                           valid_in,
  input  logic [cluster_pkg::ADR_W-1:0]  adr0, adr1, adr2, adr3, adr4, adr5, adr6, adr7,
  input  logic [cluster_pkg::CNT_W-1:0]  cnt0, cnt1, cnt2, cnt3, cnt4, cnt5, cnt6, cnt7,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [MXVPF-1:0]               vpfs_out,
  output logic [MXVPF*cluster_pkg::CNT_W-1:0] cnts_out,
  output logic [MXVPF-1:0]               strips_out
);
  import cluster_pkg::*;
  state_t state, state_nxt;
  logic [2:0] idx;
  cluster_t slots [MXCLST];
  cluster_t frame [MXCLST];
  cluster_t cur;
  logic last, start, drop;
  logic [MXVPF-1:0] vpf_acc, vpf_nxt, dec_vpf, dec_strips;
  logic [MXVPF*CNT_W-1:0] cnt_acc, cnt_nxt;
  assign frame = '{'{adr0, cnt0}, '{adr1, cnt1}, '{adr2, cnt2}, '{adr3, cnt3},
                   '{adr4, cnt4}, '{adr5, cnt5}, '{adr6, cnt6}, '{adr7, cnt7}};
  assign cur = slots[idx];
  assign busy = state == SCAN;
  cluster_slot_decoder #(.MXVPF(MXVPF)) u_dec (
    .adr(cur.adr),
    .cnt(cur.cnt),
    .vpf(dec_vpf),
    .strips(dec_strips)
  );
  // a strobe on the last scan cycle starts the next frame back-to-back
  always_comb begin
    last = state == SCAN && idx == 3'(MXCLST - 1);
    start = valid_in && (state == IDLE || last);
    drop = valid_in && state == SCAN && !last;
    state_nxt = start ? SCAN : last ? IDLE : state;
    vpf_nxt = vpf_acc | dec_vpf;
    cnt_nxt = cnt_acc;
    for (int i = 0; i < MXVPF; i++)
      if (dec_vpf[i]) cnt_nxt[CNT_W*i +: CNT_W] = cur.cnt;
  end
  always_ff @(posedge clock4x or posedge global_reset)
    if (global_reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clock4x or posedge global_reset)
    if (global_reset) begin
      idx <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
      vpf_acc <= '0;
      cnt_acc <= '0;
      vpfs_out <= '0;
      cnts_out <= '0;
      for (int i = 0; i < MXCLST; i++) slots[i] <= '{adr: ADR_INVALID, cnt: '0};
    end else begin
      done <= last;
      overflow <= drop;
      if (last) begin
        vpfs_out <= vpf_nxt;
        cnts_out <= cnt_nxt;
      end
      if (start) begin
        slots <= frame;
        idx <= '0;
        vpf_acc <= '0;
        cnt_acc <= '0;
      end else if (state == SCAN) begin
        idx <= last ? '0 : idx + 3'd1;
        vpf_acc <= vpf_nxt;
        cnt_acc <= cnt_nxt;
      end
    end
`ifdef CLUSTER_UNPACKER_STRIPS_EN
  logic [MXVPF-1:0] strip_acc;
  always_ff @(posedge clock4x or posedge global_reset)
    if (global_reset) begin
      strip_acc <= '0;
      strips_out <= '0;
    end else begin
      if (last) strips_out <= strip_acc | dec_strips;
      if (start) strip_acc <= '0;
      else if (state == SCAN) strip_acc <= strip_acc | dec_strips;
    end
`else
  assign strips_out = dec_strips;
`endif
endmodule

// File: tb/tb_cluster_unpacker.sv
// tb_cluster_unpacker: table-driven frames with a reference-model scoreboard plus timing/overflow/reset sequences
module tb_cluster_unpacker;
  import cluster_pkg::*;
  localparam int V = 1536;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0;
  logic [7:0][ADR_W-1:0] a = '1;
  logic [7:0][CNT_W-1:0] c = '0;
  logic busy, done, overflow;
  logic [V-1:0] vpfs_out, strips_out;
  logic [3*V-1:0] cnts_out;
  always #5 clk = ~clk;
  cluster_unpacker dut (
    .clock4x(clk), .global_reset(rst), .valid_in(valid_in),
    .adr0(a[0]), .adr1(a[1]), .adr2(a[2]), .adr3(a[3]),
    .adr4(a[4]), .adr5(a[5]), .adr6(a[6]), .adr7(a[7]),
    .cnt0(c[0]), .cnt1(c[1]), .cnt2(c[2]), .cnt3(c[3]),
    .cnt4(c[4]), .cnt5(c[5]), .cnt6(c[6]), .cnt7(c[7]),
    .busy(busy), .done(done), .overflow(overflow),
    .vpfs_out(vpfs_out), .cnts_out(cnts_out), .strips_out(strips_out)
  );
  typedef struct {
    logic [V-1:0] v;
    logic [3*V-1:0] c;
    logic [V-1:0] s;
  } exp_t;
  typedef struct {
    logic [7:0][ADR_W-1:0] a;
    logic [7:0][CNT_W-1:0] c;
    int pop;
    int probe;
    logic pv;
    logic [2:0] pc;
  } vec_t;
  exp_t q[$];
  exp_t e;
  vec_t tv[6];
  vec_t ts;
  int n_chk = 0, n_fail = 0, n_done = 0, n_ovf = 0;

  function automatic exp_t model(input vec_t x);
    exp_t r;
    r.v = '0;
    r.c = '0;
    r.s = '0;
    for (int k = 0; k < 8; k++) begin
      int ad;
      ad = int'(x.a[k]);
      if (ad < V) begin
        r.v[ad] = 1'b1;
        r.c[3*ad +: 3] = x.c[k];
`ifdef CLUSTER_UNPACKER_STRIPS_EN
        for (int j = ad; j <= ad + int'(x.c[k]) && j < V; j++) r.s[j] = 1'b1;
`endif
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_map(input string nm, input logic [3*V-1:0] act, input logic [3*V-1:0] exp);
    int bad;
    n_chk++;
    if (act !== exp) begin
      bad = -1;
      for (int i = 0; i < 3*V; i++)
        if (bad < 0 && act[i] !== exp[i]) bad = i;
      n_fail++;
      $display("FAIL %s: bit %0d got %b, expected %b", nm, bad, act[bad], exp[bad]);
    end
  endtask

  task automatic strobe(input vec_t x, input bit push);
    @(negedge clk);
    a = x.a;
    c = x.c;
    valid_in = 1'b1;
    if (push) q.push_back(model(x));
    @(negedge clk);
    valid_in = 1'b0;
    a = '1;
    c = '0;
  endtask

  task automatic wait_done(input string nm, input int d0);
    for (int i = 0; i < 40 && n_done <= d0; i++) begin
      @(negedge clk);
      #1;
    end
    chk(nm, n_done > d0, 1);
  endtask

  task automatic chk_probe(input string nm, input vec_t x);
    chk({nm, "_pop"}, $countones(vpfs_out), x.pop);
    chk({nm, "_pvpf"}, vpfs_out[x.probe], x.pv);
    chk({nm, "_pcnt"}, cnts_out[3*x.probe +: 3], x.pc);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (overflow) n_ovf++;
      if (done) begin
        n_done++;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no pending frame");
        end else begin
          e = q.pop_front();
          chk_map("sb_vpfs", {3072'b0, vpfs_out}, {3072'b0, e.v});
          chk_map("sb_cnts", cnts_out, e.c);
          chk_map("sb_strips", {3072'b0, strips_out}, {3072'b0, e.s});
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, o0;
    tv[0] = '{{11'd1535, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1, 11'd0}, {8{3'd3}}, 8, 1535, 1'b1, 3'd3};
    tv[1] = '{{8{ADR_INVALID}}, {8{3'd5}}, 0, 0, 1'b0, 3'd0};
    tv[2] = '{{ADR_INVALID, ADR_INVALID, ADR_INVALID, ADR_INVALID, 11'd100, ADR_INVALID, ADR_INVALID, 11'd100},
              {3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd2}, 1, 100, 1'b1, 3'd5};
    tv[3] = '{{11'd1534, 11'd1535, 11'd7, 11'd1200, 11'd2000, 11'd300, 11'd1536, 11'd10},
              {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 6, 1200, 1'b1, 3'd5};
    tv[4] = '{{8{11'd500}}, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 1, 500, 1'b1, 3'd7};
    tv[5] = '{{11'd0, 11'd200, 11'd400, 11'd600, 11'd800, 11'd1000, 11'd1400, 11'd1535},
              {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}, 8, 0, 1'b1, 3'd0};
    ts = '{{{7{ADR_INVALID}}, 11'd1534}, {{7{3'd0}}, 3'd7}, 1, 1534, 1'b1, 3'd7};
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk_map("rst_vpfs", {3072'b0, vpfs_out}, '0);
    chk_map("rst_cnts", cnts_out, '0);
    chk_map("rst_strips", {3072'b0, strips_out}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d0 = n_done;
      strobe(tv[i], 1'b1);
      wait_done($sformatf("done_v%0d", i), d0);
      chk_probe($sformatf("v%0d", i), tv[i]);
      chk($sformatf("idle_v%0d", i), busy, 0);
    end
    d0 = n_done;
    strobe(tv[0], 1'b1);
    chk("lat_busy", busy, 1);
    repeat (7) @(negedge clk);
    #1 chk("lat_early", done, 0);
    @(negedge clk);
    #1 chk("lat_done", done, 1);
    chk("lat_idle", busy, 0);
    @(negedge clk);
    #1 chk("lat_pulse", done, 0);
    d0 = n_done;
    o0 = n_ovf;
    strobe(tv[2], 1'b1);
    repeat (6) @(negedge clk);
    strobe(tv[3], 1'b1);
    #1 chk("b2b_first", n_done, d0 + 1);
    chk("b2b_busy", busy, 1);
    wait_done("b2b_second", d0 + 1);
    chk("b2b_ovf", n_ovf, o0);
    d0 = n_done;
    o0 = n_ovf;
    strobe(tv[5], 1'b1);
    @(negedge clk);
    strobe(tv[1], 1'b0);
    wait_done("ovf_first", d0);
    chk_probe("ovf", tv[5]);
    chk("ovf_count", n_ovf, o0 + 1);
    repeat (12) @(negedge clk);
    #1 chk("ovf_nodone", n_done, d0 + 1);
    chk("ovf_queue", q.size(), 0);
    d0 = n_done;
    strobe(ts, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk_map("mid_vpfs", {3072'b0, vpfs_out}, '0);
    chk_map("mid_cnts", cnts_out, '0);
    chk_map("mid_strips", {3072'b0, strips_out}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1 chk("mid_nodone", n_done, d0);
    strobe(ts, 1'b1);
    wait_done("fresh_done", d0);
    chk_probe("fresh", ts);
`ifdef CLUSTER_UNPACKER_STRIPS_EN
    chk("fresh_strips", $countones(strips_out), 2);
    chk("fresh_strip_hi", strips_out[1535:1534], 2'b11);
`else
    chk("fresh_strips", $countones(strips_out), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
